// File: rtl/object_draw_engine.sv
// object_draw_engine: streams one sprite per draw request to the VGA adapter, skipping transparent and off-screen pixels
module object_draw_engine #(
  parameter int OBJ_W = 8,
  parameter int OBJ_H = 8,
  parameter int ADDR_W = 6,
  parameter logic [2:0] TRANSPARENT = 3'b000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_draw,
  input  logic              count_clear_n,
  output logic [2:0]        obj_count,
  input  logic [8:0]        obj_x,
  input  logic [7:0]        obj_y,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [2:0]        rom_data,
  output logic [8:0]        vga_x,
  output logic [7:0]        vga_y,
  output logic [2:0]        vga_colour,
  output logic              vga_plot,
  output logic              draw_done
);
  localparam int CW = $clog2(OBJ_W);
  localparam int RW = OBJ_H > 1 ? $clog2(OBJ_H) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SCAN, FLUSH, DONE, RELEASE} state_t;
  state_t state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [8:0] bx;
  logic [7:0] by;
  logic [9:0] px;
  logic [8:0] py;
  logic pv;
  assign rom_addr = ADDR_W'(32'(row) * OBJ_W + 32'(col));
  // px/py/pv trail the address by one cycle so they line up with rom_data
  assign vga_x = px[8:0];
  assign vga_y = py[7:0];
  assign vga_colour = pv ? rom_data : '0;
  assign vga_plot = pv && rom_data != TRANSPARENT && px < 10'd320 && py < 9'd240;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      obj_count <= '0;
      col <= '0;
      row <= '0;
      bx <= '0;
      by <= '0;
      px <= '0;
      py <= '0;
      pv <= 1'b0;
      draw_done <= 1'b0;
    end else begin
      pv <= state == SCAN;
      px <= {1'b0, bx} + 10'(col);
      py <= {1'b0, by} + 9'(row);
      draw_done <= state == FLUSH;
      if (!count_clear_n) obj_count <= '0;
      else if (state == DONE && obj_count != 3'd7) obj_count <= obj_count + 3'd1;
      case (state)
        IDLE: if (enable_draw) state <= FETCH;
        FETCH: state <= enable_draw ? LOAD : IDLE;
        LOAD: begin
          state <= enable_draw ? SCAN : IDLE;
          bx <= obj_x;
          by <= obj_y;
          col <= '0;
          row <= '0;
        end
        SCAN:
          if (!enable_draw) state <= IDLE;
          else begin
            col <= col + 1'b1;
            if (col == CW'(OBJ_W - 1)) begin
              row <= row + 1'b1;
              if (row == RW'(OBJ_H - 1)) state <= FLUSH;
            end
          end
        FLUSH: state <= DONE;
        DONE: state <= RELEASE;
        RELEASE: if (!enable_draw) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_object_draw_engine.sv
// tb_object_draw_engine: random sprites and positions checked against a per-pixel reference of the draw
module tb_object_draw_engine;
  logic clk = 0, reset = 0, enable_draw = 0, count_clear_n = 1;
  logic [2:0] obj_count, rom_data, vga_colour;
  logic [8:0] obj_x, vga_x;
  logic [7:0] obj_y, vga_y;
  logic [5:0] rom_addr;
  logic vga_plot, draw_done;
  logic [2:0] rom [64];
  logic [8:0] tx [8];
  logic [7:0] ty [8];
  logic [35:0] plots [$];
  int dones [$];
  int edges = 0, t0 = 0, errors = 0, checks = 0;

  object_draw_engine dut (
    .clk(clk), .reset(reset), .enable_draw(enable_draw), .count_clear_n(count_clear_n),
    .obj_count(obj_count), .obj_x(obj_x), .obj_y(obj_y), .rom_addr(rom_addr),
    .rom_data(rom_data), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .draw_done(draw_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    edges++;
    rom_data <= rom[rom_addr];
    obj_x <= tx[obj_count];
    obj_y <= ty[obj_count];
  end

  always @(negedge clk) begin
    if (vga_plot === 1'b1) plots.push_back({16'(edges - t0), vga_x, vga_y, vga_colour});
    if (draw_done === 1'b1) dones.push_back(edges - t0);
  end

  task automatic chk(input string tag, input longint got, input longint want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic fill(input int mode);
    for (int a = 0; a < 64; a++)
      rom[a] = mode == 0 ? 3'b110 :
               mode == 1 ? (a % 2 == 0 ? 3'd0 : 3'($urandom_range(1, 7))) :
               3'($urandom_range(0, 7));
  endtask

  task automatic setpos(input int x, input int y);
    tx[obj_count] = 9'(x);
    ty[obj_count] = 8'(y);
  endtask

  task automatic draw(input int ab, input bit clr);
    logic [35:0] want [$];
    int idx, lim, x, y;
    idx = int'(obj_count);
    @(negedge clk);
    plots.delete();
    dones.delete();
    t0 = edges;
    enable_draw = 1;
    for (int k = 0; k < 90; k++) begin
      @(negedge clk);
      count_clear_n = 1;
      if (ab != 0 && edges - t0 == ab) enable_draw = 0;
      if (draw_done) begin
        enable_draw = 0;
        if (clr) count_clear_n = 0;
      end
    end
    count_clear_n = 1;
    lim = ab != 0 ? ab - 3 : 63;
    for (int a = 0; a <= lim; a++) begin
      x = int'(tx[idx]) + a % 8;
      y = int'(ty[idx]) + a / 8;
      if (rom[a] != 3'd0 && x < 320 && y < 240) want.push_back({16'(4 + a), 9'(x), 8'(y), rom[a]});
    end
    chk("plot_count", plots.size(), want.size());
    foreach (want[i]) if (i < plots.size()) chk("plot", plots[i], want[i]);
    chk("done_count", dones.size(), ab != 0 ? 0 : 1);
    if (ab == 0 && dones.size() > 0) chk("done_cycle", dones[0], 68);
    chk("obj_count", obj_count, clr ? 0 : ab != 0 ? idx : (idx == 7 ? 7 : idx + 1));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin tx[i] = 0; ty[i] = 0; end
    fill(0);
    #1 reset = 1;
    repeat (2) @(negedge clk);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_vga_x", vga_x, 0);
    chk("rst_vga_y", vga_y, 0);
    chk("rst_colour", vga_colour, 0);
    chk("rst_plot", vga_plot, 0);
    chk("rst_done", draw_done, 0);
    chk("rst_count", obj_count, 0);
    reset = 0;
    repeat (2) @(negedge clk);

    fill(0); setpos(100, 50); draw(0, 0);
    chk("opaque_plots", plots.size(), 64);
    fill(1); setpos($urandom_range(0, 312), $urandom_range(0, 232)); draw(0, 0);
    chk("even_transparent_plots", plots.size(), 32);
    fill(0); setpos(316, 236); draw(0, 0);
    chk("corner_plots", plots.size(), 16);
    fill(2); setpos(511, 255); draw(0, 0);
    for (int n = 0; n < 3; n++) begin
      fill(2); setpos($urandom_range(0, 340), $urandom_range(0, 250)); draw(0, 0);
    end
    fill(0); setpos(40, 30); draw(20, 0);
    fill(2); setpos(60, 70); draw(0, 0);

    @(negedge clk) count_clear_n = 0;
    @(negedge clk) count_clear_n = 1;
    chk("idle_clear", obj_count, 0);
    for (int i = 0; i < 8; i++) begin tx[i] = 9'($urandom_range(0, 330)); ty[i] = 8'($urandom_range(0, 245)); end
    for (int n = 0; n < 8; n++) begin fill(2); draw(0, 0); end
    chk("saturated", obj_count, 7);
    fill(2); draw(0, 1);
    fill(0); setpos(10, 10); draw(0, 0);

    setpos(100, 50);
    @(negedge clk);
    t0 = edges;
    enable_draw = 1;
    for (int k = 0; k < 40 && edges - t0 < 30; k++) @(negedge clk);
    reset = 1;
    #1;
    chk("midrst_rom_addr", rom_addr, 0);
    chk("midrst_vga_x", vga_x, 0);
    chk("midrst_vga_y", vga_y, 0);
    chk("midrst_colour", vga_colour, 0);
    chk("midrst_plot", vga_plot, 0);
    chk("midrst_done", draw_done, 0);
    chk("midrst_count", obj_count, 0);
    @(negedge clk) enable_draw = 0;
    @(negedge clk) reset = 0;
    plots.delete();
    dones.delete();
    repeat (20) @(negedge clk);
    chk("post_rst_plots", plots.size(), 0);
    chk("post_rst_dones", dones.size(), 0);
    chk("post_rst_count", obj_count, 0);
    fill(2); setpos(200, 100); draw(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
